// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM states, NOP word and
// default geometry.
package fetch_unit_pkg;

    localparam int AWIDTH_DEF     = 15;
    localparam int DWIDTH_DEF     = 32;
    localparam int RESET_ADDR_DEF = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory and the IF/ID stage.
interface fetch_unit_if #(
    parameter int AWIDTH = 15,
    parameter int DWIDTH = 32
);
    // imem handshake: once imem_req rises, imem_req and imem_addr hold until the
    // cycle imem_ack=1 (which may be the same cycle); the request is never
    // withdrawn and an ack while imem_req=0 means nothing. On the fetch side an
    // instruction is taken on every edge where fetch_valid=1 and stall=0.
    logic              stall;
    logic              redirect;
    logic [AWIDTH-1:0] redirect_addr;
    logic              imem_req;
    logic [AWIDTH-1:0] imem_addr;
    logic              imem_ack;
    logic [DWIDTH-1:0] imem_rdata;
    logic [AWIDTH-1:0] fetch_addr;
    logic [DWIDTH-1:0] fetch_instr;
    logic              fetch_valid;

    modport master (
        input  stall, redirect, redirect_addr, imem_ack, imem_rdata,
        output imem_req, imem_addr, fetch_addr, fetch_instr, fetch_valid
    );

    modport slave (
        output stall, redirect, redirect_addr, imem_ack, imem_rdata,
        input  imem_req, imem_addr, fetch_addr, fetch_instr, fetch_valid
    );

endinterface

// File: rtl/fetch_unit_skid_buf.sv
// One-entry {addr, instr} holding buffer for an instruction that returned while
// the output register was stalled.
module fetch_unit_skid_buf #(
    parameter int AWIDTH = 15,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [AWIDTH-1:0] in_addr,
    input  logic [DWIDTH-1:0] in_instr,
    output logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] instr,
    output logic              full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            addr  <= '0;
            instr <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            addr  <= in_addr;
            instr <= in_instr;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch producer: owns the PC, runs the imem req/ack handshake and
// drives the fetch output register with stall and redirect handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                AWIDTH     = AWIDTH_DEF,
    parameter int                DWIDTH     = DWIDTH_DEF,
    parameter logic [AWIDTH-1:0] RESET_ADDR = AWIDTH'(RESET_ADDR_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus,
    output fetch_state_e dbg_state
);

    fetch_state_e      state;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] pc_inc;
    logic              ack;
    logic              out_free;
    logic              consume;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_full;
    logic [AWIDTH-1:0] skid_addr;
    logic [DWIDTH-1:0] skid_instr;

    assign pc_inc   = pc + 1'b1;
    assign ack      = bus.imem_ack & bus.imem_req;
    assign out_free = ~bus.fetch_valid | ~bus.stall;
    assign consume  = bus.fetch_valid & ~bus.stall;

    // The skid only fills when data returns into a stalled, occupied output.
    assign skid_load   = (state == ST_REQ) & ack & ~bus.redirect & ~out_free;
    assign skid_unload = (state == ST_HOLD) & skid_full & ~bus.stall & ~bus.redirect;

    assign dbg_state = state;

    fetch_unit_skid_buf #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .flush    (bus.redirect),
        .in_addr  (pc),
        .in_instr (bus.imem_rdata),
        .addr     (skid_addr),
        .instr    (skid_instr),
        .full     (skid_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            pc              <= RESET_ADDR;
            bus.imem_req    <= 1'b0;
            bus.imem_addr   <= RESET_ADDR;
            bus.fetch_addr  <= '0;
            bus.fetch_instr <= DWIDTH'(NOP_INSTR);
            bus.fetch_valid <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect beats stall and ack; an in-flight request must still finish.
            pc              <= bus.redirect_addr;
            bus.fetch_addr  <= '0;
            bus.fetch_instr <= DWIDTH'(NOP_INSTR);
            bus.fetch_valid <= 1'b0;
            case (state)
                ST_REQ: begin
                    if (ack) bus.imem_addr <= bus.redirect_addr;
                    else     state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (ack) begin
                        bus.imem_addr <= bus.redirect_addr;
                        state         <= ST_REQ;
                    end
                end
                default: begin
                    bus.imem_req  <= 1'b1;
                    bus.imem_addr <= bus.redirect_addr;
                    state         <= ST_REQ;
                end
            endcase
        end else begin
            if (consume) begin
                bus.fetch_valid <= 1'b0;
                bus.fetch_instr <= DWIDTH'(NOP_INSTR);
            end
            case (state)
                ST_IDLE: begin
                    bus.imem_req  <= 1'b1;
                    bus.imem_addr <= pc;
                    state         <= ST_REQ;
                end
                ST_REQ: begin
                    if (ack) begin
                        pc <= pc_inc;
                        if (out_free) begin
                            bus.fetch_addr  <= pc;
                            bus.fetch_instr <= bus.imem_rdata;
                            bus.fetch_valid <= 1'b1;
                            bus.imem_addr   <= pc_inc;
                        end else begin
                            bus.imem_req <= 1'b0;
                            state        <= ST_HOLD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ack) begin
                        bus.imem_addr <= pc;
                        state         <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (skid_unload) begin
                        bus.fetch_addr  <= skid_addr;
                        bus.fetch_instr <= skid_instr;
                        bus.fetch_valid <= 1'b1;
                        bus.imem_req    <= 1'b1;
                        bus.imem_addr   <= pc;
                        state           <= ST_REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: wait-state memory responder, address-order
// scoreboard and directed plus randomized scenarios.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = 15;
    localparam int DW = 32;

    logic         clk;
    logic         rst;
    fetch_state_e dbg_state;

    fetch_unit_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    fetch_unit #(
        .AWIDTH     (AW),
        .DWIDTH     (DW),
        .RESET_ADDR (15'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bench state ----------------
    int            n_cmp;
    int            n_fail;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] next_push;
    logic [31:0]   salt;
    int            mem_wait;
    int            wait_cnt;
    logic          pend;
    logic [AW-1:0] pend_addr;
    int            n_steps;
    int            n_deliv;
    int            first_deliv;
    int            last_deliv;
    int            last_gap;
    logic          delivered;

    function automatic logic [31:0] mem_data(input logic [AW-1:0] a);
        return salt ^ {2'b10, a, a};
    endfunction

    task automatic sb_restart(input logic [AW-1:0] base);
        exp_q.delete();
        next_push = base;
    endtask

    task automatic clear_counts();
        pend        = 1'b0;
        wait_cnt    = 0;
        n_steps     = 0;
        n_deliv     = 0;
        first_deliv = 0;
        last_deliv  = 0;
        last_gap    = 0;
        sb_restart('0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_counts();
    endtask

    // ---------------- driver: memory responder + protocol check ----------------
    task automatic step_a();
        @(negedge clk);
        n_steps++;
        if (pend) begin
            n_cmp++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== pend_addr) begin
                n_fail++;
                $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h",
                         bus.imem_req, bus.imem_addr, pend_addr);
            end
        end
        if (bus.imem_req === 1'b1) begin
            if (wait_cnt >= mem_wait) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_data(bus.imem_addr);
                wait_cnt       = 0;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            wait_cnt       = 0;
        end
        pend      = (bus.imem_req === 1'b1) && (bus.imem_ack === 1'b0);
        pend_addr = bus.imem_addr;
        if (bus.fetch_valid !== 1'b1) begin
            n_cmp++;
            if (bus.fetch_instr !== '0) begin
                n_fail++;
                $display("FAIL nop_when_invalid: valid=%b instr=%h, required instr=0",
                         bus.fetch_valid, bus.fetch_instr);
            end
        end
    endtask

    // ---------------- driver: downstream + scoreboard ----------------
    task automatic step_b(input logic s, input logic r, input logic [AW-1:0] ra);
        logic [AW-1:0] exp;
        delivered = 1'b0;
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_push);
            next_push = next_push + 1'b1;
        end
        if (bus.fetch_valid === 1'b1 && !s && !r) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.fetch_addr !== exp || bus.fetch_instr !== mem_data(exp)) begin
                n_fail++;
                $display("FAIL fetch_order: addr=%h instr=%h, required addr=%h instr=%h",
                         bus.fetch_addr, bus.fetch_instr, exp, mem_data(exp));
            end
            delivered = 1'b1;
            n_deliv++;
            if (n_deliv == 1) first_deliv = n_steps;
            last_gap   = n_steps - last_deliv;
            last_deliv = n_steps;
        end
        if (r) sb_restart(ra);
        bus.stall         = s;
        bus.redirect      = r;
        bus.redirect_addr = ra;
    endtask

    task automatic step(input logic s, input logic r, input logic [AW-1:0] ra);
        step_a();
        step_b(s, r, ra);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        mem_wait          = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== '0 || bus.fetch_addr !== '0 ||
            bus.fetch_instr !== '0 || bus.fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b iaddr=%h faddr=%h instr=%h valid=%b, required all 0",
                     bus.imem_req, bus.imem_addr, bus.fetch_addr, bus.fetch_instr, bus.fetch_valid);
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d, required %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        clear_counts();
        step_a();
        n_cmp++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== '0 || bus.fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h valid=%b, required req=1 addr=0 valid=0",
                     bus.imem_req, bus.imem_addr, bus.fetch_valid);
        end
        step_b(1'b0, 1'b0, '0);
    endtask

    task automatic test_zero_wait();
        do_reset();
        mem_wait = 0;
        repeat (20) step(1'b0, 1'b0, '0);
        n_cmp++;
        if (n_deliv !== 19 || first_deliv !== 2) begin
            n_fail++;
            $display("FAIL zero_wait_rate: deliveries=%0d first=%0d, required 19 first=2",
                     n_deliv, first_deliv);
        end
    endtask

    task automatic test_wait2();
        do_reset();
        mem_wait = 2;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, '0);
            if (delivered && n_deliv > 1) begin
                n_cmp++;
                if (last_gap !== 3) begin
                    n_fail++;
                    $display("FAIL wait2_spacing: gap=%0d, required 3", last_gap);
                end
            end
        end
        n_cmp++;
        if (n_deliv !== 9 || first_deliv !== 4) begin
            n_fail++;
            $display("FAIL wait2_count: deliveries=%0d first=%0d, required 9 first=4",
                     n_deliv, first_deliv);
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] snap_addr;
        logic [DW-1:0] snap_instr;
        do_reset();
        mem_wait = 0;
        repeat (6) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        snap_addr  = bus.fetch_addr;
        snap_instr = bus.fetch_instr;
        for (int i = 0; i < 4; i++) begin
            step_a();
            n_cmp++;
            if (bus.fetch_valid !== 1'b1 || bus.fetch_addr !== snap_addr ||
                bus.fetch_instr !== snap_instr || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_frozen: valid=%b addr=%h instr=%h req=%b, required 1 %h %h 0",
                         bus.fetch_valid, bus.fetch_addr, bus.fetch_instr, bus.imem_req,
                         snap_addr, snap_instr);
            end
            step_b(i < 3, 1'b0, '0);
        end
        repeat (10) step(1'b0, 1'b0, '0);
        n_cmp++;
        if (n_deliv !== 16) begin
            n_fail++;
            $display("FAIL stall_count: deliveries=%0d, required 16", n_deliv);
        end
    endtask

    task automatic test_redirect_drain();
        logic found;
        logic moved;
        int   deliv_mark;
        do_reset();
        mem_wait   = 3;
        found      = 1'b0;
        moved      = 1'b0;
        deliv_mark = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step_a();
            if (bus.imem_req === 1'b1 && bus.imem_addr == 15'h0005 && bus.imem_ack === 1'b0) begin
                found      = 1'b1;
                deliv_mark = n_deliv;
                step_b(1'b0, 1'b1, 15'h0100);
            end else begin
                step_b(1'b0, 1'b0, '0);
            end
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL drain_setup: request to 0005 seen=%b, required 1", found);
        end
        step_a();
        n_cmp++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h0005 || bus.fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_hold: req=%b addr=%h valid=%b, required 1 0005 0",
                     bus.imem_req, bus.imem_addr, bus.fetch_valid);
        end
        step_b(1'b0, 1'b0, '0);
        for (int i = 0; i < 10 && !moved; i++) begin
            step_a();
            if (bus.imem_addr !== 15'h0005) begin
                moved = 1'b1;
                n_cmp++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h0100) begin
                    n_fail++;
                    $display("FAIL drain_next_req: req=%b addr=%h, required 1 0100",
                             bus.imem_req, bus.imem_addr);
                end
            end
            step_b(1'b0, 1'b0, '0);
        end
        n_cmp++;
        if (!moved) begin
            n_fail++;
            $display("FAIL drain_timeout: left 0005=%b, required 1", moved);
        end
        repeat (10) step(1'b0, 1'b0, '0);
        n_cmp++;
        if (n_deliv <= deliv_mark) begin
            n_fail++;
            $display("FAIL drain_progress: deliveries=%0d, required > %0d", n_deliv, deliv_mark);
        end
    endtask

    task automatic test_redirect_hold();
        logic [AW-1:0] tgt;
        int            deliv_mark;
        do_reset();
        mem_wait = 0;
        tgt      = AW'($urandom_range(0, 32'h7FFF));
        repeat (4) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step_a();
        n_cmp++;
        if (bus.imem_req !== 1'b0 || bus.fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_entry: req=%b valid=%b, required 0 1", bus.imem_req, bus.fetch_valid);
        end
        deliv_mark = n_deliv;
        step_b(1'b1, 1'b1, tgt);
        step_a();
        n_cmp++;
        if (bus.fetch_valid !== 1'b0 || bus.fetch_instr !== '0 || bus.fetch_addr !== '0 ||
            bus.imem_req !== 1'b1 || bus.imem_addr !== tgt) begin
            n_fail++;
            $display("FAIL hold_redirect: valid=%b instr=%h faddr=%h req=%b iaddr=%h, required 0 0 0 1 %h",
                     bus.fetch_valid, bus.fetch_instr, bus.fetch_addr, bus.imem_req, bus.imem_addr, tgt);
        end
        step_b(1'b0, 1'b0, '0);
        repeat (6) step(1'b0, 1'b0, '0);
        n_cmp++;
        if (n_deliv - deliv_mark < 5) begin
            n_fail++;
            $display("FAIL hold_progress: deliveries=%0d, required >= 5", n_deliv - deliv_mark);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic seen_top;
        logic wrap_checked;
        do_reset();
        mem_wait     = 0;
        seen_top     = 1'b0;
        wrap_checked = 1'b0;
        step(1'b0, 1'b1, 15'h7FFE);
        for (int i = 0; i < 8; i++) begin
            step_a();
            if (seen_top && !wrap_checked) begin
                wrap_checked = 1'b1;
                n_cmp++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 15'h0000) begin
                    n_fail++;
                    $display("FAIL wrap_addr: req=%b addr=%h, required 1 0000", bus.imem_req, bus.imem_addr);
                end
            end
            seen_top = (bus.imem_req === 1'b1) && (bus.imem_addr == 15'h7FFF) && (bus.imem_ack === 1'b1);
            step_b(1'b0, 1'b0, '0);
        end
        n_cmp++;
        if (!wrap_checked) begin
            n_fail++;
            $display("FAIL wrap_timeout: wrap seen=%b, required 1", wrap_checked);
        end

        // reset with a request pending, then a stray ack right after release
        mem_wait = 3;
        repeat (2) step(1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== '0 || bus.fetch_addr !== '0 ||
            bus.fetch_instr !== '0 || bus.fetch_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL async_reset: req=%b iaddr=%h faddr=%h instr=%h valid=%b state=%0d, required all 0",
                     bus.imem_req, bus.imem_addr, bus.fetch_addr, bus.fetch_instr, bus.fetch_valid, dbg_state);
        end
        @(negedge clk);
        rst            = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        clear_counts();
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== '0) begin
            n_fail++;
            $display("FAIL late_ack: valid=%b req=%b addr=%h, required 0 1 0000",
                     bus.fetch_valid, bus.imem_req, bus.imem_addr);
        end
        bus.imem_ack = 1'b0;
        repeat (12) step(1'b0, 1'b0, '0);
        n_cmp++;
        if (n_deliv !== 2) begin
            n_fail++;
            $display("FAIL post_reset_count: deliveries=%0d, required 2", n_deliv);
        end
    endtask

    task automatic test_random();
        logic          s;
        logic          r;
        logic [AW-1:0] ra;
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            mem_wait = $urandom_range(0, 3);
            for (int i = 0; i < 60; i++) begin
                s  = ($urandom_range(0, 99) < 30);
                r  = ($urandom_range(0, 99) < 4);
                ra = AW'($urandom_range(0, 32'h7FFF));
                step(s, r, ra);
            end
        end
        repeat (20) step(1'b0, 1'b0, '0);
        n_cmp++;
        if (n_deliv < 10) begin
            n_fail++;
            $display("FAIL random_progress: deliveries=%0d, required >= 10", n_deliv);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        salt   = $urandom;
        clear_counts();
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_redirect_drain();
        test_redirect_hold();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
